// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, opcode legality.
package seq_alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_LSL   = 4'b1000;
  localparam logic [3:0] OP_LSR   = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  // True for every opcode the ALU implements
  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PASSB, OP_LSL, OP_LSR, OP_MUL: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/seq_alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial-product step per cycle.
// The product register starts as {0, B}; each step conditionally adds A to the
// upper half and shifts the whole register right by one.
module alu_mul_iter
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 last_o,
  output logic [2*WIDTH-1:0]   prod_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] step_prod_s;
  logic [WIDTH:0]     partial_s;
  logic [CW-1:0]      cnt_q, cnt_d;

  // One shift-add step and next-state selection (load / step / hold)
  always_comb begin
    partial_s   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                  (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    step_prod_s = {partial_s, prod_q[WIDTH-1:1]};
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
    if (load_i) begin
      mcand_d = a_i;
      prod_d  = {{WIDTH{1'b0}}, b_i};
      cnt_d   = {CW{1'b0}};
    end else if (step_i) begin
      prod_d  = step_prod_s;
      cnt_d   = cnt_q + CW'(1'b1);
    end else begin
      prod_d  = prod_q;
    end
  end

  // The final step's product is handed to the top in the same cycle it is formed
  assign last_o = step_i && (cnt_q == CNT_LAST);
  assign prod_o = step_prod_s;

  // Multiplier state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_q <= {WIDTH{1'b0}};
      prod_q  <= {(2*WIDTH){1'b0}};
      cnt_q   <= {CW{1'b0}};
    end else begin
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus an iterative MUL,
// registered result and flags, Start/Busy/Done handshake.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       ALUCtrl,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow,
  output logic             IllegalOp,
  output logic             Busy,
  output logic             Done
);

  localparam int SH_W = $clog2(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] busw_q;
  logic             carry_q, ovf_q, illegal_q, busy_q, done_q;

  logic [WIDTH:0]     sum_s, diff_s;
  logic [SH_W-1:0]    shamt_s;
  logic [WIDTH-1:0]   res_s;
  logic               carry_s, ovf_s, illegal_s;
  logic               mul_load_s, mul_step_s, mul_last_s;
  logic [2*WIDTH-1:0] mul_prod_s;

  assign sum_s   = {1'b0, BusA} + {1'b0, BusB};
  assign diff_s  = {1'b0, BusA} - {1'b0, BusB};
  assign shamt_s = BusB[SH_W-1:0];

  assign mul_load_s = Start && (state_q == S_IDLE) && (ALUCtrl == OP_MUL);
  assign mul_step_s = (state_q == S_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk_i  (CLK),
    .rst_i  (Reset),
    .load_i (mul_load_s),
    .step_i (mul_step_s),
    .a_i    (BusA),
    .b_i    (BusB),
    .last_o (mul_last_s),
    .prod_o (mul_prod_s)
  );

  // Single-cycle result and flag candidates for the current opcode
  always_comb begin
    res_s     = {WIDTH{1'b0}};
    carry_s   = 1'b0;
    ovf_s     = 1'b0;
    illegal_s = !is_legal_op(ALUCtrl);
    case (ALUCtrl)
      OP_AND:   res_s = BusA & BusB;
      OP_OR:    res_s = BusA | BusB;
      OP_ADD: begin
        res_s   = sum_s[WIDTH-1:0];
        carry_s = sum_s[WIDTH];
        ovf_s   = (BusA[WIDTH-1] == BusB[WIDTH-1]) && (sum_s[WIDTH-1] != BusA[WIDTH-1]);
      end
      OP_SUB: begin
        res_s   = diff_s[WIDTH-1:0];
        carry_s = !diff_s[WIDTH];
        ovf_s   = (BusA[WIDTH-1] != BusB[WIDTH-1]) && (diff_s[WIDTH-1] != BusA[WIDTH-1]);
      end
      OP_PASSB: res_s = BusB;
      OP_LSL:   res_s = BusA << shamt_s;
      OP_LSR:   res_s = BusA >> shamt_s;
      OP_MUL:   res_s = {WIDTH{1'b0}};
      default:  res_s = {WIDTH{1'b0}};
    endcase
  end

  // Control FSM with registered result, flags and handshake outputs
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      busw_q    <= {WIDTH{1'b0}};
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            if (ALUCtrl == OP_MUL) begin
              state_q <= S_MUL;
              busy_q  <= 1'b1;
            end else begin
              busw_q    <= res_s;
              carry_q   <= carry_s;
              ovf_q     <= ovf_s;
              illegal_q <= illegal_s;
              done_q    <= 1'b1;
            end
          end
        end
        S_MUL: begin
          // Start is ignored here; only the last multiply step ends the op
          if (mul_last_s) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            busw_q    <= mul_prod_s[WIDTH-1:0];
            carry_q   <= 1'b0;
            ovf_q     <= |mul_prod_s[2*WIDTH-1:WIDTH];
            illegal_q <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign BusW      = busw_q;
  assign Zero      = (busw_q == {WIDTH{1'b0}});
  assign Negative  = busw_q[WIDTH-1];
  assign Carry     = carry_q;
  assign Overflow  = ovf_q;
  assign IllegalOp = illegal_q;
  assign Busy      = busy_q;
  assign Done      = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=64): directed corner cases plus
// random operations against a plain-arithmetic reference model.
module tb_seq_alu;

  localparam logic [3:0] T_AND = 4'b0000, T_OR = 4'b0001, T_ADD = 4'b0010, T_SUB = 4'b0110;
  localparam logic [3:0] T_PASSB = 4'b0111, T_LSL = 4'b1000, T_LSR = 4'b1001, T_MUL = 4'b1010;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [3:0]  ALUCtrl = 4'b0000;
  logic [63:0] BusA = 64'd0, BusB = 64'd0;
  logic [63:0] BusW;
  logic        Zero, Negative, Carry, Overflow, IllegalOp, Busy, Done;

  int checks_cnt = 0;
  int errors_cnt = 0;

  seq_alu #(.WIDTH(64)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .ALUCtrl(ALUCtrl),
    .BusA(BusA), .BusB(BusB), .BusW(BusW), .Zero(Zero), .Negative(Negative),
    .Carry(Carry), .Overflow(Overflow), .IllegalOp(IllegalOp), .Busy(Busy), .Done(Done)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: result, carry, overflow, illegal from the opcode table using plain arithmetic
  function automatic void model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] r, output logic c, output logic v,
                                output logic ill);
    logic [64:0]         u;
    logic signed [65:0]  sa, sb, ss;
    logic [127:0]        p;
    r = 64'd0; c = 1'b0; v = 1'b0; ill = 1'b0;
    sa = {{2{a[63]}}, a};
    sb = {{2{b[63]}}, b};
    case (op)
      T_AND:   r = a & b;
      T_OR:    r = a | b;
      T_ADD: begin
        u = {1'b0, a} + {1'b0, b};
        r = u[63:0]; c = u[64];
        ss = sa + sb;
        v = !((ss[65:63] == 3'b000) || (ss[65:63] == 3'b111));
      end
      T_SUB: begin
        r = a - b; c = (a >= b);
        ss = sa - sb;
        v = !((ss[65:63] == 3'b000) || (ss[65:63] == 3'b111));
      end
      T_PASSB: r = b;
      T_LSL:   r = a << b[5:0];
      T_LSR:   r = a >> b[5:0];
      T_MUL: begin
        p = {64'd0, a} * {64'd0, b};
        r = p[63:0]; v = (p[127:64] != 64'd0);
      end
      default: ill = 1'b1;
    endcase
  endfunction

  // Issue one op, wait (bounded) for Done, check latency, result, flags and hold
  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input bit repulse);
    logic [63:0] er;
    logic        ec, ev, ei;
    int          busy_n, wait_n;
    model(op, a, b, er, ec, ev, ei);
    @(negedge CLK);
    Start = 1'b1; ALUCtrl = op; BusA = a; BusB = b;
    @(negedge CLK);
    Start = 1'b0; ALUCtrl = 4'($urandom); BusA = {$urandom, $urandom}; BusB = {$urandom, $urandom};
    busy_n = 0; wait_n = 0;
    while (!Done && wait_n < 200) begin
      if (Busy) busy_n++;
      if (repulse && wait_n == 4) begin
        Start = 1'b1; ALUCtrl = T_ADD; BusA = 64'd5; BusB = 64'd9;
      end else begin
        Start = 1'b0;
      end
      @(negedge CLK);
      wait_n++;
    end
    Start = 1'b0;
    check_eq("done_seen", Done, 1'b1);
    check_eq("busy_cycles", busy_n, (op == T_MUL) ? 64 : 0);
    check_eq("busy_at_done", Busy, 1'b0);
    check_eq("busw", BusW, er);
    check_eq("zero", Zero, er == 64'd0);
    check_eq("negative", Negative, er[63]);
    check_eq("carry", Carry, ec);
    check_eq("overflow", Overflow, ev);
    check_eq("illegal", IllegalOp, ei);
    @(negedge CLK);
    check_eq("done_pulse_len", Done, 1'b0);
    check_eq("busw_hold", BusW, er);
  endtask

  initial begin
    logic [3:0]  rop;
    int          done_n;
    // Reset state
    @(negedge CLK);
    check_eq("rst_busw", BusW, 64'd0);
    check_eq("rst_busy", Busy, 1'b0);
    check_eq("rst_done", Done, 1'b0);
    check_eq("rst_flags", {Negative, Carry, Overflow, IllegalOp}, 4'b0000);
    @(negedge CLK);
    Reset = 1'b0;

    // Directed corner cases
    run_op(T_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    run_op(T_SUB, 64'h8000_0000_0000_0000, 64'd1, 1'b0);
    run_op(T_MUL, 64'd7, 64'd6, 1'b1);
    run_op(T_LSL, 64'd1, 64'd63, 1'b0);
    run_op(T_LSR, 64'h8000_0000_0000_0000, 64'h43, 1'b0);
    run_op(T_SUB, 64'd3, 64'd5, 1'b0);
    run_op(T_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

    // Illegal opcode, then AND issued on its Done cycle
    @(negedge CLK);
    Start = 1'b1; ALUCtrl = 4'b0011; BusA = 64'h1234; BusB = 64'h5678;
    @(negedge CLK);
    check_eq("ill_done", Done, 1'b1);
    check_eq("ill_busw", BusW, 64'd0);
    check_eq("ill_zero", Zero, 1'b1);
    check_eq("ill_flag", IllegalOp, 1'b1);
    Start = 1'b1; ALUCtrl = T_AND; BusA = 64'hF0F0_1234_5678_9ABC; BusB = 64'hFF00_FF00_FF00_FF00;
    @(negedge CLK);
    Start = 1'b0;
    check_eq("b2b_done", Done, 1'b1);
    check_eq("b2b_busw", BusW, 64'hF000_1200_5600_9A00);
    check_eq("b2b_illegal", IllegalOp, 1'b0);

    // Reset in the middle of a multiply
    @(negedge CLK);
    Start = 1'b1; ALUCtrl = T_MUL; BusA = 64'd123; BusB = 64'd456;
    @(negedge CLK);
    Start = 1'b0;
    repeat (9) @(negedge CLK);
    check_eq("mid_busy_before", Busy, 1'b1);
    #1 Reset = 1'b1;
    #2;
    check_eq("mid_rst_busy", Busy, 1'b0);
    check_eq("mid_rst_done", Done, 1'b0);
    check_eq("mid_rst_busw", BusW, 64'd0);
    @(negedge CLK);
    Reset = 1'b0;
    done_n = 0;
    repeat (70) begin
      @(negedge CLK);
      if (Done) done_n++;
    end
    check_eq("mid_rst_no_done", done_n, 0);
    run_op(T_ADD, 64'd40, 64'd2, 1'b0);

    // Random operations, including illegal opcodes and large shift amounts
    for (int i = 0; i < 40; i++) begin
      rop = (i % 10 == 3) ? T_MUL : 4'($urandom_range(0, 15));
      run_op(rop, {$urandom, $urandom}, (i % 4 == 0) ? 64'($urandom_range(0, 255))
                                                      : {$urandom, $urandom}, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
